// File: rtl/tqvp_arb_pkg.sv
// -----------------------------------------------------------------------------
// tqvp_arb_pkg
// Shared definitions for the two-master peripheral register arbiter.
//   - default address / data widths of the byte-wide register port
//   - FSM state encoding (IDLE -> ACCESS -> RESP)
//   - requester index constants (SPI bridge = 0, sequencer = 1)
//   - helper to turn a requester index into a one-hot vector
// No ports (package).
// -----------------------------------------------------------------------------
package tqvp_arb_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic REQ_SPI = 1'b0;
   localparam logic REQ_SEQ = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ACCESS = ST_ACCESS,
      S_RESP   = ST_RESP
   } arb_state_t;

   // One-hot vector selecting the given requester.
   function automatic logic [1:0] idx_to_onehot(input logic idx);
      logic [1:0] oh;
      if (idx == REQ_SEQ) begin
         oh = 2'b10;
      end else begin
         oh = 2'b01;
      end
      return oh;
   endfunction

endpackage

// File: rtl/tqvp_rr_arb2.sv
// -----------------------------------------------------------------------------
// tqvp_rr_arb2
// Two-way request picker used by the register arbiter.
//   Default build: round-robin. When both requesters are active the pointer
//   decides; after each completed transaction the pointer moves to favour the
//   requester that did not win. Pointer resets to 0 (requester 0 favoured).
//   With TQVP_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and no
//   pointer state exists (ptr reads as 0).
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [1:0] request vector
//   update  in   strobe: a transaction has just completed
//   winner  in   index of the requester that completed (valid with update)
//   grant   out  [1:0] one-hot grant (combinational, 0 when no request)
//   ptr     out  requester index currently favoured on a tie
// -----------------------------------------------------------------------------
module tqvp_rr_arb2
   import tqvp_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       winner,
   output logic [1:0] grant,
   output logic       ptr
);

   logic [1:0] grant_s;

`ifdef TQVP_ARB_FIXED_PRIO_EN

   // Fixed priority needs no history, so these inputs are deliberately unused.
   logic unused_s;
   assign unused_s = ^{clk, rst_n, update, winner};

   // Requester 0 wins every tie; requester 1 may starve.
   always_comb begin
      grant_s = 2'b00;
      case (req)
         2'b01:   grant_s = 2'b01;
         2'b10:   grant_s = 2'b10;
         2'b11:   grant_s = 2'b01;
         default: grant_s = 2'b00;
      endcase
   end

   assign ptr = 1'b0;

`else

   logic ptr_r;

   // Tie-break follows the pointer; a lone requester always wins.
   always_comb begin
      grant_s = 2'b00;
      case (req)
         2'b01:   grant_s = 2'b01;
         2'b10:   grant_s = 2'b10;
         2'b11:   grant_s = idx_to_onehot(ptr_r);
         default: grant_s = 2'b00;
      endcase
   end

   // Pointer register: after a transaction, favour the requester that lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= REQ_SPI;
      end else if (update) begin
         ptr_r <= ~winner;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

`endif

   assign grant = grant_s;

endmodule

// File: rtl/tqvp_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tqvp_reg_arbiter
// Shares the single byte-wide peripheral register port between two
// requesters (0: SPI register bridge, 1: sequencer / test master).
// Every access runs IDLE -> ACCESS -> RESP, one access per three cycles:
//   IDLE   arbitrate; latch winner's address (and write data on writes),
//          raise data_write for writes.
//   ACCESS address stable; data_write high for this cycle only on writes;
//          on reads data_out is captured into rdata at the end of the cycle.
//   RESP   ack[winner] high for this single cycle; pointer advances.
// Requests are only looked at in IDLE, so a req still high during RESP is
// never granted twice, and address/data/we changes after the grant are
// ignored. A dropped req mid-transaction still completes and is acked.
// Optional feature macro: TQVP_ARB_FIXED_PRIO_EN (fixed priority, requester 0
// wins ties) -- otherwise round-robin.
// Ports:
//   clk         in   clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   req[1:0]    in   per-requester request, held until that requester's ack
//   we[1:0]     in   per-requester write (1) / read (0), valid with req
//   addr0/1     in   per-requester register address
//   wdata0/1    in   per-requester write data
//   ack[1:0]    out  one-cycle one-hot completion pulse (registered)
//   rdata       out  read data, valid in the ack cycle (registered)
//   address     out  peripheral address (registered)
//   data_in     out  peripheral write data (registered)
//   data_write  out  peripheral write strobe (registered)
//   data_out    in   peripheral read data, combinational on address
// -----------------------------------------------------------------------------
module tqvp_reg_arbiter
   import tqvp_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_in,
   output logic              data_write,
   input  logic [DATA_W-1:0] data_out
);

   arb_state_t        state_r, state_s;
   logic [1:0]        grant_s;
   logic              grant_idx_s;
   logic              ptr_s;
   logic              arb_upd_s;
   logic              win_r, win_s;
   logic              we_r, we_s;
   logic [ADDR_W-1:0] address_r, address_s;
   logic [DATA_W-1:0] data_in_r, data_in_s;
   logic              data_write_r, data_write_s;
   logic [1:0]        ack_r, ack_s;
   logic [DATA_W-1:0] rdata_r, rdata_s;

   // The pointer value is only of interest for observation; nothing here needs it.
   logic unused_ptr_s;
   assign unused_ptr_s = ptr_s;

   tqvp_rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .update (arb_upd_s),
      .winner (win_r),
      .grant  (grant_s),
      .ptr    (ptr_s)
   );

   // Winner index from the one-hot grant (only meaningful when grant_s != 0).
   always_comb begin
      grant_idx_s = REQ_SPI;
      if (grant_s == 2'b10) begin
         grant_idx_s = REQ_SEQ;
      end else begin
         grant_idx_s = REQ_SPI;
      end
   end

   // Next-state and next-output logic for the three-phase access sequence.
   always_comb begin
      state_s      = state_r;
      win_s        = win_r;
      we_s         = we_r;
      address_s    = address_r;
      data_in_s    = data_in_r;
      data_write_s = 1'b0;
      ack_s        = 2'b00;
      rdata_s      = rdata_r;
      arb_upd_s    = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (grant_s != 2'b00) begin
               win_s = grant_idx_s;
               we_s  = we[grant_idx_s];
               if (grant_idx_s == REQ_SEQ) begin
                  address_s = addr1;
               end else begin
                  address_s = addr0;
               end
               // A read leaves data_in untouched.
               if (we_s && (grant_idx_s == REQ_SEQ)) begin
                  data_in_s = wdata1;
               end else if (we_s) begin
                  data_in_s = wdata0;
               end else begin
                  data_in_s = data_in_r;
               end
               data_write_s = we_s;
               state_s      = S_ACCESS;
            end else begin
               state_s = S_IDLE;
            end
         end

         S_ACCESS: begin
            // data_out settles on the stable address during this cycle.
            if (we_r) begin
               rdata_s = rdata_r;
            end else begin
               rdata_s = data_out;
            end
            ack_s   = idx_to_onehot(win_r);
            state_s = S_RESP;
         end

         S_RESP: begin
            arb_upd_s = 1'b1;
            state_s   = S_IDLE;
         end

         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Transaction context and registered peripheral/requester outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_r        <= REQ_SPI;
         we_r         <= 1'b0;
         address_r    <= {ADDR_W{1'b0}};
         data_in_r    <= {DATA_W{1'b0}};
         data_write_r <= 1'b0;
         ack_r        <= 2'b00;
         rdata_r      <= {DATA_W{1'b0}};
      end else begin
         win_r        <= win_s;
         we_r         <= we_s;
         address_r    <= address_s;
         data_in_r    <= data_in_s;
         data_write_r <= data_write_s;
         ack_r        <= ack_s;
         rdata_r      <= rdata_s;
      end
   end

   assign ack        = ack_r;
   assign rdata      = rdata_r;
   assign address    = address_r;
   assign data_in    = data_in_r;
   assign data_write = data_write_r;

endmodule

// File: doc/tqvp_reg_arbiter.md
Name: tqvp_reg_arbiter

Overview:
Two-master arbiter that shares the single byte-wide peripheral register port (4-bit address, 8-bit write data, write strobe, combinational read data) between requesters. Typical requesters are the SPI register bridge and an on-chip sequencer or test master. The block sequences each access through a fixed 3-cycle FSM. It guarantees exactly one data_write pulse per write and one ack per transaction.

Parameters:
ADDR_W, 4, register address width
DATA_W, 8, register data width

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  2  per-requester request; held high until that requester's ack
we  input  2  per-requester write (1) / read (0), valid with req
addr0  input  ADDR_W  requester 0 address
addr1  input  ADDR_W  requester 1 address
wdata0  input  DATA_W  requester 0 write data
wdata1  input  DATA_W  requester 1 write data
ack  output  2  one-cycle completion pulse, one-hot
rdata  output  DATA_W  read data, valid in the ack cycle
address  output  ADDR_W  to peripheral, registered
data_in  output  DATA_W  to peripheral, registered
data_write  output  1  to peripheral, registered write strobe
data_out  input  DATA_W  from peripheral, combinational on address

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: ack=0, rdata=0, address=0, data_in=0, data_write=0. FSM=IDLE. RR pointer=0, so requester 0 is favoured next.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick a winner. If only one requester is active, it wins. If both are active, the requester the pointer favours wins.
  - Latch the winner's addr into address. On a write, also latch its wdata into data_in.
  - Register data_write = winner's we. Store the winner index and we. Go to ACCESS.
- ACCESS:
  - address is stable. data_write is high for exactly this cycle on writes.
  - On reads, data_out is sampled into rdata at the end of the cycle.
  - data_write is cleared at the end of the cycle. Go to RESP.
- RESP:
  - ack[winner]=1 for this single cycle. rdata holds the read value; on writes rdata is unchanged.
  - Pointer is updated to favour the non-winner. Always go to IDLE.
- Latency: req seen high in IDLE at cycle N. ACCESS is cycle N+1, ack is at N+2. The earliest next grant is N+3.
- The requester must drop or renew req in the cycle after ack. Because arbitration only happens in IDLE, a req still high during RESP is never double-granted.
- Throughput: one access per 3 cycles. No pipelining.
- address and data_in hold their last value while idle. A read does not update data_in.
- Protocol violation: if req drops mid-transaction, the transaction still completes and ack is still issued.
- Inputs are sampled only in IDLE. Changes to addr, wdata or we after the grant are ignored.
- Reset mid-operation: the FSM goes to IDLE immediately and data_write and ack clear asynchronously. The in-flight transaction is dropped with no ack. The requester re-requests after reset.
- Simultaneous requests under round-robin: strict alternation while both are held. Neither requester waits more than one transaction.

Optional Feature:
- Macro: TQVP_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both request. The pointer is not implemented, and requester 1 can starve.
- Undefined (default): round-robin arbitration as described above.

Decomposition:
- Shared package tqvp_arb_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - requester-index constants REQ_SPI=0, REQ_SEQ=1;
  - default ADDR_W and DATA_W.
- One sub-module, tqvp_rr_arb2: a 2-way round-robin picker.
  - Inputs: req[1:0], update strobe.
  - Outputs: one-hot grant and pointer.
  - The macro selects fixed priority inside it.

Test Plan:
- Write: req0 with we0=1, addr0=0x3, wdata0=0xA5 after reset → address=3, data_in=0xA5, data_write high for exactly 1 cycle; ack=2'b01 two cycles after req is seen.
- Read: req1 with we1=0, addr1=0x5, peripheral model returns 0x5C at address 5 → ack=2'b10 with rdata=0x5C; data_write stays 0 throughout.
- Contention: req=2'b11 held across 4 transactions, starting from reset → ack order 0,1,0,1. With TQVP_ARB_FIXED_PRIO_EN defined → 0,0,0,0.
- Hold after ack: req0 kept high one extra cycle past ack, req1 pending → next grant goes to requester 1, with no duplicate ack to requester 0.
- Reset mid-write: rst_n asserted during ACCESS of a write to 0x7 → data_write falls without waiting for a clock edge, no ack, FSM in IDLE; after release a re-issued request completes normally.
- Input churn: addr0 changes from 0x2 to 0x9 in the ACCESS cycle → address stays 0x2 and the read returns the value at address 2.
